// File: rtl/lcd_pkg.sv
// Shared types and helpers for the character-LCD bus responder.
// Opcode masks, DDRAM geometry and address-counter arithmetic.
package lcd_pkg;

  localparam logic [6:0] LINE0_END  = 7'h27;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE1_END  = 7'h67;
  localparam int         DDRAM_DEPTH = 80;
  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [7:0] M_DDRAM = 8'h80;
  localparam logic [7:0] M_CGRAM = 8'h40;
  localparam logic [7:0] M_FUNC  = 8'h20;
  localparam logic [7:0] M_SHIFT = 8'h10;
  localparam logic [7:0] M_DISP  = 8'h08;
  localparam logic [7:0] M_ENTRY = 8'h04;
  localparam logic [7:0] M_HOME  = 8'h02;
  localparam logic [7:0] M_CLEAR = 8'h01;

  typedef enum logic [1:0] {
    ST_SWEEP,
    ST_IDLE,
    ST_BUSY
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DISP,
    OP_SHIFT,
    OP_FUNC,
    OP_CGRAM,
    OP_DDRAM
  } op_e;

  typedef struct packed {
    logic id;
    logic s;
    logic d;
    logic c;
    logic b;
    logic dl;
    logic n;
    logic f;
    logic cg;
  } mode_t;

  localparam mode_t MODE_RST = '{
    id: 1'b1, s: 1'b0, d: 1'b0, c: 1'b0, b: 1'b0,
    dl: 1'b1, n: 1'b0, f: 1'b0, cg: 1'b0
  };

  // Highest set bit selects the instruction.
  function automatic op_e decode_op(input logic [7:0] b);
    op_e op;
    op = OP_NONE;
    if ((b & M_DDRAM) != '0)      op = OP_DDRAM;
    else if ((b & M_CGRAM) != '0) op = OP_CGRAM;
    else if ((b & M_FUNC) != '0)  op = OP_FUNC;
    else if ((b & M_SHIFT) != '0) op = OP_SHIFT;
    else if ((b & M_DISP) != '0)  op = OP_DISP;
    else if ((b & M_ENTRY) != '0) op = OP_ENTRY;
    else if ((b & M_HOME) != '0)  op = OP_HOME;
    else if ((b & M_CLEAR) != '0) op = OP_CLEAR;
    return op;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= LINE0_END) ||
           ((a >= LINE1_BASE) && (a <= LINE1_END));
  endfunction

  function automatic logic [6:0] addr_index(input logic [6:0] a);
    return (a >= LINE1_BASE) ? a - 7'h18 : a;
  endfunction

  // Step with the two-line wrap in either direction.
  function automatic logic [6:0] ac_step(
    input logic [6:0] a,
    input logic       inc
  );
    logic [6:0] r;
    if (inc) begin
      if (a == LINE0_END)      r = LINE1_BASE;
      else if (a == LINE1_END) r = 7'h00;
      else                     r = a + 7'd1;
    end else begin
      if (a == 7'h00)           r = LINE1_END;
      else if (a == LINE1_BASE) r = LINE0_END;
      else                      r = a - 7'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchroniser for the LCD bus pins.
// Flags the falling edge of the synchronised enable.
module lcd_bus_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic       e,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] db_in,
  output logic       e_s,
  output logic       rs_s,
  output logic       rw_s,
  output logic [7:0] db_s,
  output logic       fall
);

  logic [10:0] s1_q;
  logic [10:0] s2_q;
  logic        e_d_q;

  // Two sync stages plus a delayed copy of e for edge detect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      e_d_q <= 1'b0;
    end else begin
      s1_q  <= {e, rs, rw, db_in};
      s2_q  <= s1_q;
      e_d_q <= s2_q[10];
    end
  end

  assign {e_s, rs_s, rw_s, db_s} = s2_q;
  assign fall = e_d_q & ~e_s;

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style bus responder standing in for a character LCD.
// Holds DDRAM, address counter, busy timing and mode bits.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int unsigned CLEAR_BUSY_CYCLES = 82000,
  parameter int unsigned CMD_BUSY_CYCLES   = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       e,
  input  logic [7:0] db_in,
  output logic [7:0] db_out,
  output logic       db_oe,
  output logic       busy,
  output logic       disp_on,
  output logic [6:0] ac,
  output logic       bus_error,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  logic       e_s;
  logic       rs_s;
  logic       rw_s;
  logic [7:0] db_s;
  logic       fall;

  lcd_bus_sync u_sync (
    .clock (clock),
    .reset (reset),
    .e     (e),
    .rs    (rs),
    .rw    (rw),
    .db_in (db_in),
    .e_s   (e_s),
    .rs_s  (rs_s),
    .rw_s  (rw_s),
    .db_s  (db_s),
    .fall  (fall)
  );

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [6:0]  ac_q, ac_d;
  logic [6:0]  sweep_q, sweep_d;
  mode_t       mode_q, mode_d;
  logic        err_q, err_d;

  logic        wr_en;
  logic [6:0]  wr_idx;
  logic [7:0]  wr_val;
  logic [7:0]  mem [DDRAM_DEPTH];

  logic        wr_stb;
  logic        rd_stb;
  logic        wr_ok;
  op_e         op;
  logic [7:0]  rd_word;
  logic        unused_mode;

  assign busy   = (cnt_q != '0);
  assign wr_stb = fall & ~rw_s;
  assign rd_stb = fall & rw_s;
  assign wr_ok  = wr_stb & ~busy;
  assign op     = decode_op(db_s);

  // Next state, counter, mode bits and DDRAM write port.
  always_comb begin
    state_d = state_q;
    cnt_d   = busy ? cnt_q - 32'd1 : cnt_q;
    ac_d    = ac_q;
    sweep_d = sweep_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = sweep_q;
    wr_val  = SPACE;

    unique case (state_q)
      ST_SWEEP: begin
        wr_en   = 1'b1;
        sweep_d = sweep_q + 7'd1;
        if (sweep_q == 7'(DDRAM_DEPTH - 1)) begin
          state_d = (cnt_d != '0) ? ST_BUSY : ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_d == '0) state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (wr_stb && busy) err_d = 1'b1;

    if (rd_stb && rs_s) ac_d = ac_step(ac_q, mode_q.id);

    if (wr_ok) begin
      cnt_d   = CMD_BUSY_CYCLES;
      state_d = ST_BUSY;
      if (rs_s) begin
        if (!mode_q.cg) begin
          wr_en  = 1'b1;
          wr_idx = addr_index(ac_q);
          wr_val = db_s;
        end
        ac_d = ac_step(ac_q, mode_q.id);
      end else begin
        unique case (op)
          OP_CLEAR: begin
            state_d   = ST_SWEEP;
            sweep_d   = '0;
            ac_d      = '0;
            mode_d.id = 1'b1;
            cnt_d     = CLEAR_BUSY_CYCLES;
          end
          OP_HOME: begin
            ac_d  = '0;
            cnt_d = CLEAR_BUSY_CYCLES;
          end
          OP_ENTRY: begin
            mode_d.id = db_s[1];
            mode_d.s  = db_s[0];
          end
          OP_DISP: begin
            mode_d.d = db_s[2];
            mode_d.c = db_s[1];
            mode_d.b = db_s[0];
          end
          OP_SHIFT: begin
            if (!db_s[3]) ac_d = ac_step(ac_q, db_s[2]);
          end
          OP_FUNC: begin
            if (!db_s[4]) begin
              err_d = 1'b1;
            end else begin
              mode_d.dl = db_s[4];
              mode_d.n  = db_s[3];
              mode_d.f  = db_s[2];
            end
          end
          OP_CGRAM: mode_d.cg = 1'b1;
          OP_DDRAM: begin
            mode_d.cg = 1'b0;
            if (addr_valid(db_s[6:0])) ac_d = db_s[6:0];
            else err_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Control registers; reset restarts the power-on sweep.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SWEEP;
      cnt_q   <= 32'(DDRAM_DEPTH);
      ac_q    <= '0;
      sweep_q <= '0;
      mode_q  <= MODE_RST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ac_q    <= ac_d;
      sweep_q <= sweep_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // DDRAM storage, filled by the sweep after reset or clear.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_val;
  end

  assign rd_word = mem[addr_index(ac_q)];

  assign db_oe   = e_s & rw_s;
  assign db_out  = !db_oe ? 8'h00 :
                   rs_s   ? rd_word : {busy, ac_q};
  assign rd_data = (rd_addr < 7'(DDRAM_DEPTH)) ?
                   mem[rd_addr] : 8'h00;

  assign ac        = ac_q;
  assign disp_on   = mode_q.d;
  assign bus_error = err_q;

  assign unused_mode = ^{mode_q.s, mode_q.c, mode_q.b,
                         mode_q.dl, mode_q.n, mode_q.f};

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomised bench for lcd_bus_responder.
// Reference model tracks the display in linear-index terms.
module tb_lcd_bus_responder;

  localparam int CLR = 200;
  localparam int CMD = 24;

  logic       clock;
  logic       reset;
  logic       rs;
  logic       rw;
  logic       e;
  logic [7:0] db_in;
  logic [7:0] db_out;
  logic       db_oe;
  logic       busy;
  logic       disp_on;
  logic [6:0] ac;
  logic       bus_error;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  lcd_bus_responder #(
    .CLEAR_BUSY_CYCLES (CLR),
    .CMD_BUSY_CYCLES   (CMD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rs        (rs),
    .rw        (rw),
    .e         (e),
    .db_in     (db_in),
    .db_out    (db_out),
    .db_oe     (db_oe),
    .busy      (busy),
    .disp_on   (disp_on),
    .ac        (ac),
    .bus_error (bus_error),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_cmp;
  int n_bad;

  logic [7:0] m_ram [80];
  logic [6:0] m_ac;
  bit         m_id;
  bit         m_d;
  bit         m_cg;
  int         busy_end;
  int         sweep_end;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int m_lin(input logic [6:0] a);
    return (a < 7'h40) ? int'(a) : int'(a) - 24;
  endfunction

  function automatic logic [6:0] m_step(
    input logic [6:0] a,
    input bit         inc
  );
    int i;
    i = m_lin(a);
    i = inc ? (i + 1) % 80 : (i + 79) % 80;
    return (i < 40) ? 7'(i) : 7'(i + 24);
  endfunction

  function automatic bit m_valid(input logic [6:0] a);
    return (a <= 7'd39) || (a >= 7'd64 && a <= 7'd103);
  endfunction

  function automatic void m_init();
    m_ac      = '0;
    m_id      = 1'b1;
    m_d       = 1'b0;
    m_cg      = 1'b0;
    busy_end  = 80;
    sweep_end = 80;
    for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
  endfunction

  // Write strobe with pin fall at n; returns expected bus_error.
  function automatic bit m_write(
    input bit         r,
    input logic [7:0] d,
    input int         n
  );
    bit err;
    err = 1'b0;
    if (n + 2 < busy_end) return 1'b1;
    busy_end = n + 3 + CMD;
    if (r) begin
      if (!m_cg) m_ram[m_lin(m_ac)] = d;
      m_ac = m_step(m_ac, m_id);
    end else if (d[7]) begin
      m_cg = 1'b0;
      if (m_valid(d[6:0])) m_ac = d[6:0];
      else err = 1'b1;
    end else if (d[6]) begin
      m_cg = 1'b1;
    end else if (d[5]) begin
      if (!d[4]) err = 1'b1;
    end else if (d[4]) begin
      if (!d[3]) m_ac = m_step(m_ac, d[2]);
    end else if (d[3]) begin
      m_d = d[2];
    end else if (d[2]) begin
      m_id = d[1];
    end else if (d[1]) begin
      m_ac = '0;
      busy_end = n + 3 + CLR;
    end else if (d[0]) begin
      m_ac = '0;
      m_id = 1'b1;
      busy_end  = n + 3 + CLR;
      sweep_end = n + 3 + 81;
      for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
    end
    return err;
  endfunction

  task automatic bus_wr(input bit r, input logic [7:0] d);
    int n;
    bit err;
    @(negedge clock);
    rs = r; rw = 1'b0; db_in = d; e = 1'b1;
    repeat (3) @(negedge clock);
    e = 1'b0;
    n = cyc;
    err = m_write(r, d, n);
    repeat (3) @(negedge clock);
    chk("wr_err", bus_error, err);
    chk("wr_busy", busy, cyc < busy_end);
    chk("wr_ac", ac, m_ac);
    chk("wr_disp", disp_on, m_d);
    chk("wr_oe", db_oe, 0);
    @(negedge clock);
    chk("err_pulse", bus_error, 0);
  endtask

  task automatic bus_rd(input bit r);
    @(negedge clock);
    rs = r; rw = 1'b1; e = 1'b1;
    @(negedge clock);
    chk("oe_early", db_oe, 0);
    @(negedge clock);
    chk("oe_rise", db_oe, 1);
    if (!r) chk("rd_status", db_out, {cyc < busy_end, m_ac});
    else if (cyc >= sweep_end)
      chk("rd_data", db_out, m_ram[m_lin(m_ac)]);
    @(negedge clock);
    e = 1'b0;
    if (r) m_ac = m_step(m_ac, m_id);
    @(negedge clock);
    chk("oe_hold", db_oe, 1);
    @(negedge clock);
    chk("oe_fall", db_oe, 0);
    @(negedge clock);
    chk("rd_ac", ac, m_ac);
  endtask

  task automatic wait_idle();
    if (cyc < busy_end) begin
      while (cyc < busy_end - 1) @(negedge clock);
      chk("busy_hold", busy, 1);
      @(negedge clock);
      chk("busy_drop", busy, 0);
    end
  endtask

  task automatic check_ram();
    for (int i = 0; i < 82; i++) begin
      rd_addr = 7'(i);
      #1;
      chk($sformatf("ram%0d", i), rd_data,
          (i < 80) ? m_ram[i] : 8'h00);
    end
    rd_addr = 7'h7f;
    #1;
    chk("ram_oob", rd_data, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clock);
    e = 1'b0; rw = 1'b0; rs = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_ac", ac, 0);
    repeat (3) @(negedge clock);
    m_init();
    reset = 1'b1;
    #1;
    chk("rst_oe", db_oe, 0);
    chk("rst_dout", db_out, 8'h00);
    chk("rst_disp", disp_on, 0);
    chk("rst_err", bus_error, 0);
    chk("rst_busy2", busy, 1);
  endtask

  initial begin
    logic [7:0] b;
    int k;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    rs = 1'b0; rw = 1'b0; e = 1'b0;
    db_in = '0; rd_addr = '0;
    m_init();

    do_reset();
    wait_idle();
    chk("init_ac", ac, 0);
    check_ram();

    bus_wr(0, 8'h38); wait_idle();
    bus_wr(0, 8'h0C); wait_idle();
    bus_wr(0, 8'h06); wait_idle();
    bus_wr(1, 8'h41); wait_idle();
    chk("disp_on", disp_on, 1);
    rd_addr = 7'd0; #1;
    chk("ram0_41", rd_data, 8'h41);
    chk("ac_01", ac, 7'h01);

    bus_wr(0, 8'hA7); wait_idle();
    bus_wr(1, 8'h5A); wait_idle();
    bus_wr(1, 8'h59); wait_idle();
    rd_addr = 7'd39; #1;
    chk("ram39", rd_data, 8'h5A);
    rd_addr = 7'd40; #1;
    chk("ram40", rd_data, 8'h59);
    chk("ac_41", ac, 7'h41);
    bus_wr(0, 8'hE8);
    chk("bad_addr_ac", ac, 7'h41);

    bus_wr(1, 8'h42);
    bus_rd(0);
    wait_idle();
    check_ram();

    for (int i = 0; i < 6; i++) begin
      bus_wr(1, 8'($urandom_range(33, 126)));
      wait_idle();
    end
    bus_wr(0, 8'h01);
    chk("clr_ac", ac, 0);
    wait_idle();
    check_ram();
    bus_rd(1);
    chk("rd_ac1", ac, 7'h01);

    wait_idle();
    bus_wr(0, 8'h01);
    repeat (30) @(negedge clock);
    do_reset();
    wait_idle();
    check_ram();

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) < 7) wait_idle();
      k = $urandom_range(0, 9);
      b = 8'($urandom);
      if (k <= 3) begin
        bus_wr(1, b);
      end else if (k <= 6) begin
        case ($urandom_range(0, 8))
          0: b = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h06;
          1: b = 8'h02 | (b & 8'h01);
          2: b = 8'h04 | (b & 8'h03);
          3: b = 8'h08 | (b & 8'h07);
          4: b = 8'h10 | (b & 8'h0F);
          5: b = 8'h20 | (b & 8'h1F);
          6: b = 8'h40 | (b & 8'h3F);
          default: b = 8'h80 | b;
        endcase
        bus_wr(0, b);
      end else if (k == 7) begin
        bus_rd(0);
      end else if (k == 8) begin
        bus_rd(1);
      end else if (cyc >= sweep_end) begin
        k = $urandom_range(0, 79);
        rd_addr = 7'(k); #1;
        chk("spot", rd_data, m_ram[k]);
      end
    end
    wait_idle();
    check_ram();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
